// File: rtl/oh_arbiter_rr_if.sv
// Request/grant bundle between a set of requesters and the round-robin arbiter.
// The master modport is the arbiter side; the slave modport is the requester side.
interface oh_arbiter_rr_if #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          ready;
    logic [N-1:0]  grant;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          beat;

    modport master (
        input  req, last, ready,
        output grant, gnt_valid, gnt_id, beat
    );

    modport slave (
        output req, last, ready,
        input  grant, gnt_valid, gnt_id, beat
    );
endinterface

// File: rtl/oh_arbiter_rr.sv
// Round-robin burst arbiter: locks the grant to one requester until its burst
// completes or it withdraws, then hands off without a bubble cycle.
module oh_arbiter_rr #(
    parameter int N    = 4,
    parameter     PROP = "DEFAULT",
    parameter int IW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              nreset,
    oh_arbiter_rr_if.master   bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    // Implementation tags select no alternative logic today; every variant is this one.
    if (PROP != "DEFAULT") begin : g_prop_variant
    end

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win, cand;
    logic          found;
    logic          beat;
    logic          done;
    int            scan;

    assign beat = (state_q == OWNED) & bus.req[id_q] & bus.ready;

    // A withdrawn request ends ownership exactly like a completed burst.
    assign done = (state_q == OWNED) & (~bus.req[id_q] | (beat & bus.last[id_q]));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        win     = '0;
        cand    = '0;
        scan    = 0;

        if (done) begin
            ptr_d = (int'(id_q) == N - 1) ? '0 : id_q + 1'b1;
        end

        // Scan from the (possibly just updated) pointer so handoff needs no extra cycle.
        for (int k = 0; k < N; k++) begin
            scan = int'(ptr_d) + k;
            if (scan >= N) scan = scan - N;
            cand = IW'(scan);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        if ((state_q == IDLE) || done) begin
            if (found) begin
                state_d = OWNED;
                grant_d = {{(N-1){1'b0}}, 1'b1} << win;
                id_d    = win;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, and state uses non-blocking assignments only.
        if (!nreset) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.gnt_valid = (state_q == OWNED);
    assign bus.gnt_id    = id_q;
    assign bus.beat      = beat;

endmodule

// File: tb/tb_oh_arbiter_rr.sv
// Directed and randomized bench for oh_arbiter_rr (N=4) against a burst-level
// reference model that tracks only the current owner and the priority pointer.
module tb_oh_arbiter_rr;

    localparam int N = 4;

    logic clk = 1'b0;
    logic nreset;
    int   total = 0;
    int   bad   = 0;

    // Reference model: owner index (-1 when nobody owns) and top-priority requester.
    int   m_owner = -1;
    int   m_ptr   = 0;

    oh_arbiter_rr_if #(.N(N)) bus ();

    oh_arbiter_rr #(.N(N)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check beat, advance the model, check registered outputs.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy,
                        input logic rst_n);
        logic exp_beat;
        @(negedge clk);
        bus.req   = r;
        bus.last  = l;
        bus.ready = rdy;
        nreset    = rst_n;
        #1;
        exp_beat = (m_owner >= 0) && r[m_owner] && rdy;
        check("beat", 32'(bus.beat), 32'(exp_beat));

        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
        end else if (!r[m_owner] || (exp_beat && l[m_owner])) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = pick(r, m_ptr);
        end

        @(posedge clk);
        #1;
        check("grant", 32'(bus.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
        check("gnt_id", 32'(bus.gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    endtask

    task automatic do_reset();
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [N-1:0] seq [5];
        logic [N-1:0] r, l;
        logic         rdy, rn;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus.req   = '0;
        bus.last  = '0;
        bus.ready = 1'b0;
        nreset    = 1'b0;

        // Reset state; requests during reset must not be granted.
        do_reset();
        step(4'b1111, 4'b0000, 1'b1, 1'b0);
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_id", 32'(bus.gnt_id), 32'd0);

        // Two requesters, no completion: requester 1 wins and holds.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 4'b0000, 1'b1, 1'b1);
            check("hold_1010_grant", 32'(bus.grant), 32'b0010);
            check("hold_1010_id", 32'(bus.gnt_id), 32'd1);
        end

        // All request, every beat completes: rotation without bubbles.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 4'b1111, 1'b1, 1'b1);
            check("rotate_grant", 32'(bus.grant), 32'(seq[i]));
            check("rotate_valid", 32'(bus.gnt_valid), 32'd1);
        end

        // Requester 2 stalled by ready=0 with last high, then completes; ptr moves to 3.
        do_reset();
        step(4'b0100, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 4'b0100, 1'b0, 1'b1);
            check("stall_grant", 32'(bus.grant), 32'b0100);
        end
        step(4'b1111, 4'b0100, 1'b1, 1'b1);
        check("after_stall_grant", 32'(bus.grant), 32'b1000);

        // Abort: owner 1 withdraws while requester 3 waits.
        do_reset();
        step(4'b0010, 4'b0000, 1'b0, 1'b1);
        step(4'b1000, 4'b0000, 1'b0, 1'b1);
        check("abort_grant", 32'(bus.grant), 32'b1000);

        // Mid-burst reset drops the grant and restarts priority at requester 0.
        do_reset();
        step(4'b0001, 4'b0000, 1'b1, 1'b1);
        step(4'b0001, 4'b0000, 1'b1, 1'b0);
        check("midreset_grant", 32'(bus.grant), 32'd0);
        check("midreset_id", 32'(bus.gnt_id), 32'd0);
        step(4'b0110, 4'b0000, 1'b1, 1'b1);
        check("post_reset_grant", 32'(bus.grant), 32'b0010);

        // Single requester completing every cycle re-wins at lowest priority.
        do_reset();
        step(4'b0001, 4'b0001, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, 4'b0001, 1'b1, 1'b1);
            check("self_regrant", 32'(bus.grant), 32'b0001);
            check("self_beat", 32'(bus.beat), 32'd1);
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r   = N'($urandom_range(0, (1 << N) - 1));
            l   = N'($urandom_range(0, (1 << N) - 1));
            rdy = 1'($urandom_range(0, 1));
            rn  = ($urandom_range(0, 59) != 0);
            step(r, l, rdy, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oh_arbiter_rr.md
OH_ARBITER_RR -- requirements
Module: oh_arbiter_rr

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one resource; legal range 2..16.
REQ-002 Parameter PROP, default "DEFAULT", implementation property string; SHALL NOT alter function.
REQ-003 Parameter IW, default $clog2(N), width of gnt_id.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 nreset  input  1  reset, synchronous and active-low.
REQ-006 req  input  N  per-requester request; requester i asserts req[i] and holds it for the duration of its burst.
REQ-007 last  input  N  per-requester end-of-burst marker; last[i] is qualified only while the burst beat is accepted.
REQ-008 ready  input  1  resource accepts a beat this cycle.
REQ-009 grant  output  N  registered one-hot grant, or all-zero.
REQ-010 gnt_valid  output  1  registered; high when grant is non-zero.
REQ-011 gnt_id  output  IW  registered binary index of the granted requester; 0 when gnt_valid is low.
REQ-012 beat  output  1  combinational; high when gnt_valid & req[gnt_id] & ready.

Function
REQ-013 The block SHALL have two states: IDLE (grant zero) and OWNED (grant one-hot, locked to one requester).
REQ-014 Round-robin pointer ptr SHALL hold the index of the highest-priority requester; priority descends ptr, ptr+1, ..., ptr+N-1, modulo N.
REQ-015 IDLE with any req bit set: at the next edge, SHALL enter OWNED granting the first set req bit in priority order. Latency is 1 cycle from req to grant.
REQ-016 IDLE with req all-zero: SHALL remain IDLE.
REQ-017 OWNED: grant SHALL be held unchanged while req[gnt_id] stays high and no completion occurs, regardless of other req bits or ready.
REQ-018 Completion SHALL be defined as beat & last[gnt_id]. On completion, ptr SHALL become (gnt_id+1) mod N at the same edge.
REQ-019 Back-to-back handoff: on completion, the next grant SHALL be computed from the current-cycle req, using the updated ptr. If any req bit is set (the finishing requester included, at lowest priority), the block SHALL stay OWNED with the new winner at the next edge, with no bubble cycle. Otherwise it SHALL go to IDLE.
REQ-020 Abort: in OWNED, if req[gnt_id] is low, the block SHALL treat the cycle as completion (ptr update, rearbitration per REQ-019), independent of ready and last.
REQ-021 last bits of non-granted requesters, and last[gnt_id] without beat, SHALL be ignored.
REQ-022 Starvation bound: a continuously asserted req[i] SHALL be granted within N-1 completed bursts of other requesters.
REQ-023 N not a power of two: pointer increment SHALL wrap to 0 after N-1. Indices >= N SHALL never appear.

Reset
REQ-024 While nreset is low at a clock edge, the block SHALL set grant=0, gnt_valid=0, gnt_id=0, ptr=0 and state=IDLE.
REQ-025 Reset asserted mid-burst SHALL drop the grant at that edge, with no completion semantics. After release, arbitration SHALL restart with requester 0 at highest priority.
REQ-026 Arbitration SHALL begin no earlier than the first edge with nreset high; the first grant appears one cycle after that edge.

Verification (N=4)
REQ-027 After reset, req=4'b1010 with ready=1 and last=0 for 3 cycles -> grant=4'b0010 and gnt_id=1 one cycle after req, and held for all 3 cycles.
REQ-028 req=4'b1111 constant, ready=1, last always 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, changing every cycle with gnt_valid constantly high (no bubble).
REQ-029 Requester 2 owns the grant, ready=0 with last[2]=1 for 5 cycles, then ready=1 -> grant unchanged for 5 cycles and released only after the ready cycle; ptr=3 afterwards.
REQ-030 Requester 1 owns the grant, req[1] drops with last=0 while req[3]=1 -> next edge grant=4'b1000.
REQ-031 Requester 0 owns the grant, nreset low for one cycle mid-burst -> grant=0 and gnt_id=0 at that edge; with req=4'b0110 after release, the first grant is 4'b0010.
REQ-032 Only req[0] asserted, completing every cycle -> grant stays 4'b0001 continuously (self-regrant at lowest priority), with beat high each cycle.
